// File: rtl/spi_sclk_gen_if.sv
// Control and strobe bundle between the SPI controller (master) and the
// serial-clock generator (slave).
interface spi_sclk_gen_if #(
   parameter int DIV_W = 3
);
   logic [DIV_W-1:0] divider;
   logic             cpol;
   logic             cs;
   logic             sclk;
   logic             sclk_pe;
   logic             sclk_ne;

   modport master (
      output divider, cpol, cs,
      input  sclk, sclk_pe, sclk_ne
   );

   modport slave (
      input  divider, cpol, cs,
      output sclk, sclk_pe, sclk_ne
   );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: power-of-two divider gated by active-low chip
// select, idle level set by CPOL, with one-cycle rising/falling edge strobes.

module spi_edge_rise_det (
   input  logic clk,
   input  logic rst,
   input  logic rst_val_i,
   input  logic sig_i,
   output logic pulse_o
);
   logic sig_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) sig_q <= rst_val_i;
      else     sig_q <= sig_i;
   end

   assign pulse_o = sig_i & ~sig_q;
endmodule

module spi_edge_fall_det (
   input  logic clk,
   input  logic rst,
   input  logic rst_val_i,
   input  logic sig_i,
   output logic pulse_o
);
   logic sig_q;

   always_ff @(posedge clk) begin
      if (rst) sig_q <= rst_val_i;
      else     sig_q <= sig_i;
   end

   assign pulse_o = ~sig_i & sig_q;
endmodule

module spi_sclk_core #(
   parameter int DIV_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] divider_i,
   input  logic             cpol_i,
   input  logic             cs_i,
   output logic             sclk_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_m1;
   logic             sclk_q, sclk_d;

   assign half_m1 = (CNT_W'(1) << divider_i) - CNT_W'(1);

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      cnt_d  = '0;
      sclk_d = cpol_i;
      // Only a clean 0 runs the clock; 1, X or Z all fall through to idle.
      if (cs_i == 1'b0) begin
         if (cnt_q >= half_m1) begin
            sclk_d = ~sclk_q;
         end else begin
            sclk_d = sclk_q;
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= cpol_i;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
endmodule

module spi_sclk_gen #(
   parameter int DIV_W = 3,
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   spi_sclk_gen_if.slave  bus_if
);
   logic sclk_w;
   logic pe_w;
   logic ne_w;

   spi_sclk_core #(
      .DIV_W (DIV_W),
      .CNT_W (CNT_W)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .divider_i (bus_if.divider),
      .cpol_i    (bus_if.cpol),
      .cs_i      (bus_if.cs),
      .sclk_o    (sclk_w)
   );

   // Detectors reset to cpol so a reset-forced return to idle makes no strobe.
   spi_edge_rise_det u_rise (
      .clk       (clk),
      .rst       (rst),
      .rst_val_i (bus_if.cpol),
      .sig_i     (sclk_w),
      .pulse_o   (pe_w)
   );

   spi_edge_fall_det u_fall (
      .clk       (clk),
      .rst       (rst),
      .rst_val_i (bus_if.cpol),
      .sig_i     (sclk_w),
      .pulse_o   (ne_w)
   );

   assign bus_if.sclk    = sclk_w;
   assign bus_if.sclk_pe = pe_w;
   assign bus_if.sclk_ne = ne_w;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: reset, divide ratios, cs gating, divider
// shrink mid-run, reset mid-run and cpol change while idle.
module tb_spi_sclk_gen;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   pe_cnt;
   int   ne_cnt;

   spi_sclk_gen_if #(.DIV_W(3)) bus_if ();

   spi_sclk_gen #(
      .DIV_W (3),
      .CNT_W (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic s, input logic pe, input logic ne);
      check({tag, ".sclk"}, 32'(bus_if.sclk), 32'(s));
      check({tag, ".pe"}, 32'(bus_if.sclk_pe), 32'(pe));
      check({tag, ".ne"}, 32'(bus_if.sclk_ne), 32'(ne));
   endtask

   task automatic do_reset(input logic pol, input logic [2:0] div);
      rst            = 1'b1;
      bus_if.cs      = 1'b1;
      bus_if.cpol    = pol;
      bus_if.divider = div;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic exp_s;
      n_tests = 0;
      n_fail  = 0;
      rst            = 1'b1;
      bus_if.cs      = 1'b0;
      bus_if.cpol    = 1'b1;
      bus_if.divider = 3'd0;

      // Reset held 2 cycles with cs low; first toggle one cycle after release.
      tick();
      check_out("rst1", 1'b1, 1'b0, 1'b0);
      tick();
      check_out("rst2", 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      check_out("rst_rel", 1'b0, 1'b0, 1'b1);

      // divider=0: sclk toggles every clk, 8 strobes of each kind in 16 cycles.
      do_reset(1'b0, 3'd0);
      check_out("d0_idle", 1'b0, 1'b0, 1'b0);
      bus_if.cs = 1'b0;
      pe_cnt = 0;
      ne_cnt = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_s = (k % 2) == 1;
         check_out($sformatf("d0_k%0d", k), exp_s, exp_s, ~exp_s);
         if (bus_if.sclk_pe) pe_cnt++;
         if (bus_if.sclk_ne) ne_cnt++;
         check($sformatf("d0_overlap_k%0d", k), 32'(bus_if.sclk_pe & bus_if.sclk_ne), 32'd0);
      end
      check("d0_pe_cnt", 32'(pe_cnt), 32'd8);
      check("d0_ne_cnt", 32'(ne_cnt), 32'd8);

      // divider=2: H=4, toggles on posedges 4, 8, 12, 16.
      do_reset(1'b0, 3'd2);
      bus_if.cs = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_s = ((k / 4) % 2) == 1;
         check_out($sformatf("d2_k%0d", k), exp_s,
                   (k == 4) || (k == 12), (k == 8) || (k == 16));
      end

      // cs raised during the high phase, then lowered: full half-period restart.
      do_reset(1'b0, 3'd2);
      bus_if.cs = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      check_out("cs_mid_hi", 1'b1, 1'b0, 1'b0);
      bus_if.cs = 1'b1;
      tick();
      check_out("cs_up", 1'b0, 1'b0, 1'b1);
      tick();
      check_out("cs_up_hold", 1'b0, 1'b0, 1'b0);
      bus_if.cs = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_out($sformatf("cs_re_k%0d", k), k == 4, k == 4, 1'b0);
      end

      // divider 7 -> 0 at cnt=50: immediate toggle, then every cycle.
      do_reset(1'b0, 3'd7);
      bus_if.cs = 1'b0;
      for (int k = 1; k <= 50; k++) tick();
      check_out("shrink_pre", 1'b0, 1'b0, 1'b0);
      bus_if.divider = 3'd0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp_s = (k % 2) == 1;
         check_out($sformatf("shrink_k%0d", k), exp_s, exp_s, ~exp_s);
      end

      // Reset mid-run while sclk=1: back to 0 with no falling strobe.
      do_reset(1'b0, 3'd0);
      bus_if.cs = 1'b0;
      tick();
      check_out("mrst_pre", 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      check_out("mrst", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // cpol toggled while idle: sclk follows with a legitimate edge strobe.
      do_reset(1'b0, 3'd1);
      bus_if.cpol = 1'b1;
      tick();
      check_out("cpol_idle", 1'b1, 1'b1, 1'b0);
      tick();
      check_out("cpol_idle_hold", 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
SPI serial-clock generator with built-in SCLK edge detection for the SPI leader/follower controller. It divides the system clock by a programmable power of two and gates it with active-low chip select. Idle level is set by CPOL. It emits single-cycle rising- and falling-edge strobes, which the controller uses to time its shift and sample operations.

Parameters:
- DIV_W, 3, width of divider input
- CNT_W, 8, half-period counter width; must hold 2^(2^DIV_W - 1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- divider  in  DIV_W  half-period select: H = 2^divider clk cycles
- cpol  in  1  SPI clock polarity (idle level of sclk)
- cs  in  1  chip select, active low; 0 = clock runs, anything else = idle
- sclk  out  1  generated SPI clock, registered
- sclk_pe  out  1  one-cycle strobe: sclk rose
- sclk_ne  out  1  one-cycle strobe: sclk fell

Behaviour:
- Internal state: cnt[CNT_W], sclk register, sclk_d (previous-cycle copy of sclk).
- Reset (rst=1 at posedge): sclk<=cpol, sclk_d<=cpol, cnt<=0. Result: sclk=cpol, sclk_pe=0, sclk_ne=0. rst has priority over everything, including mid-transfer.
- Idle (rst=0, cs!=0 including X/Z): sclk<=cpol, cnt<=0.
- Run (rst=0, cs==0), each posedge:
  - if cnt >= H-1: sclk<=~sclk, cnt<=0
  - else: cnt<=cnt+1
  - Using >= rather than == prevents wrap when divider shrinks mid-run.
- Timing:
  - First toggle occurs on the H-th posedge with cs sampled low.
  - sclk period = 2H clk cycles, duty 50%.
  - divider=0 gives clk/2; divider=7 gives clk/256.
- First edge direction: with cpol=0 the first edge is rising; with cpol=1 it is falling.
- divider and cpol are sampled every cycle, with no shadowing:
  - a divider change takes effect at the next compare;
  - a cpol change while cs=0 has no effect until idle.
- Edge detect:
  - sclk_d <= sclk every non-reset posedge.
  - sclk_pe = sclk & ~sclk_d, sclk_ne = ~sclk & sclk_d (combinational).
  - Each strobe is high for exactly one clk cycle, in the cycle sclk holds its new value.
  - sclk_pe and sclk_ne are never high simultaneously.
- Side effects that produce legitimate edge pulses (the controller gates with cs):
  - cs rising while sclk != cpol: sclk returns to cpol on the next posedge.
  - cpol toggled while idle: sclk follows cpol.
- Counting: H-1 zero-length gaps between toggles. No other latency.
- Implementation structure:
  - reusable rising-edge and falling-edge detector submodules (sig, clk, rst → pulse);
  - a divider/counter core;
  - top-level wiring.

Test Plan:
- Reset: rst=1 for 2 cycles with cpol=1, cs=0 → sclk=1, sclk_pe=0, sclk_ne=0. After release, first toggle to 0 after exactly 1 cycle (divider=0).
- divider=0, cpol=0, cs=0 for 16 cycles → sclk alternates every clk. 8 sclk_pe and 8 sclk_ne pulses, each 1 cycle wide, never overlapping.
- divider=2, cpol=0, cs=0 → sclk high 4 cycles and low 4 cycles. Period 8. First sclk_pe on the 4th posedge after cs low.
- cs raised mid-high-phase (cpol=0) → sclk=0 next posedge with one sclk_ne pulse. cnt cleared. Re-lowering cs restarts a full half-period.
- divider changed from 7 to 0 when cnt=50 → sclk toggles on the next posedge (>= compare), then every cycle; no wrap stall.
- rst asserted mid-run with cpol=0 while sclk=1 → sclk=0 next posedge with no sclk_ne strobe (sclk_d also reset).
